ysyx_22041207_axi_rd_slave: RTL and testbench

//  Read responder for the fetch-side read port: accepts an address/size handshake, reads an internal

---
 rtl/ysyx_22041207_bus_pkg.sv | 29 ++
 rtl/ysyx_22041207_lfsr8.sv | 19 +
 rtl/ysyx_22041207_axi_rd_slave.sv | 124 ++++++++++++
 tb/tb_ysyx_22041207_axi_rd_slave.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_bus_pkg.sv
// Shared definitions for the fetch-side read bus: FSM encoding, default base address, size masks,
// and the right-align/byte-mask helper used to build a read beat.
package ysyx_22041207_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [63:0] BUS_BASE_ADDR = 64'h8000_0000;
    localparam logic [7:0]  SIZE_W        = 8'h0F;
    localparam logic [7:0]  SIZE_D        = 8'hFF;

    // Bytes shifted in from past the word end are zero; a read never crosses into the next word.
    function automatic logic [63:0] align_mask(input logic [63:0] word,
                                               input logic [2:0]  off,
                                               input logic [7:0]  size);
        logic [63:0] sh;
        logic [63:0] res;
        sh  = word >> {off, 3'b000};
        res = '0;
        for (int n = 0; n < 8; n++) begin
            res[8*n +: 8] = size[n] ? sh[8*n +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22041207_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), loads seed on reset, steps once per enabled cycle.
// Zero latency to output; no backpressure, the enable is the only advance condition.
module ysyx_22041207_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/ysyx_22041207_axi_rd_slave.sv
// Read responder with programmable latency; response is sticky until the next address is accepted.
// RD_SLAVE_RAND_DELAY_EN adds 0..7 pseudo-random WAIT cycles per read.
module ysyx_22041207_axi_rd_slave
    import ysyx_22041207_bus_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = BUS_BASE_ADDR,
    parameter int          MEM_WORDS = 65536,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_r_valid_i,
    output logic        rx_r_ready_o,
    input  logic [63:0] rx_r_addr_i,
    input  logic [7:0]  rx_r_size_i,
    output logic [63:0] rx_data_read_o,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    output logic        rd_err
);

    localparam int          IDXW     = $clog2(MEM_WORDS);
    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_WORDS) * 64'd8;

    logic [63:0] mem [MEM_WORDS];

    state_t      state;
    logic [63:0] addr_q;
    logic [7:0]  size_q;
    logic [7:0]  cnt;
    logic [7:0]  extra;
    logic [7:0]  cnt_init;
    logic        accept;

    assign accept   = rx_r_valid_i && rx_r_ready_o;
    assign cnt_init = 8'(LATENCY) + extra;

`ifdef RD_SLAVE_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    ysyx_22041207_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .seed  (8'hA5),
        .q     (lfsr_q)
    );

    assign extra = 8'(3'(lfsr_q));
`else
    assign extra = 8'd0;
`endif

    // With zero latency the beat is built straight from the request in IDLE.
    logic [63:0]     ld_addr;
    logic [7:0]      ld_size;
    logic            in_range;
    logic [IDXW-1:0] word_idx;
    logic [63:0]     ld_data;

    always_comb begin
        ld_addr  = (state == ST_IDLE) ? rx_r_addr_i : addr_q;
        ld_size  = (state == ST_IDLE) ? rx_r_size_i : size_q;
        in_range = (ld_addr >= BASE_ADDR) && (ld_addr < END_ADDR);
        word_idx = IDXW'((ld_addr - BASE_ADDR) >> 3);
        ld_data  = in_range ? align_mask(mem[word_idx], ld_addr[2:0], ld_size) : 64'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rx_r_ready_o   <= 1'b1;
            rx_data_valid  <= 1'b0;
            rx_data_read_o <= 64'd0;
            rd_err         <= 1'b0;
            cnt            <= 8'd0;
            addr_q         <= 64'd0;
            size_q         <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q       <= rx_r_addr_i;
                        size_q       <= rx_r_size_i;
                        rx_r_ready_o <= 1'b0;
                        cnt          <= cnt_init;
                        if (cnt_init == 8'd0) begin
                            rx_data_read_o <= ld_data;
                            rd_err         <= !in_range;
                            rx_data_valid  <= 1'b1;
                            state          <= ST_RESP;
                        end else begin
                            rx_data_valid <= 1'b0;
                            state         <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt <= 8'd1) begin
                        rx_data_read_o <= ld_data;
                        rd_err         <= !in_range;
                        rx_data_valid  <= 1'b1;
                        state          <= ST_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    // valid/data stay up after the handshake: the initiator samples on valid && !ready
                    if (rx_data_ready) begin
                        rx_r_ready_o <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    rx_r_ready_o <= 1'b1;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_slave.sv
// Directed bench for the read responder: reset, latency, sticky response, range errors, reset abort.
module tb_ysyx_22041207_axi_rd_slave;
    import ysyx_22041207_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_valid = 1'b0;
    logic [63:0] r_addr = 64'd0;
    logic [7:0]  r_size = 8'd0;
    logic        d_ready = 1'b0;
    logic        r_ready;
    logic [63:0] d_data;
    logic        d_valid;
    logic        rd_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] tb_mem [4] = '{64'h1122334455667788, 64'hA1A2A3A4A5A6A7A8,
                                64'h0F1E2D3C4B5A6978, 64'hDEADBEEFCAFEF00D};
    logic [7:0]  sz_tab [8] = '{8'hFF, 8'h0F, 8'h03, 8'h01, 8'hF0, 8'hAA, 8'h55, 8'h3C};
    localparam logic [63:0] LAST_WORD = 64'h0123456789ABCDEF;

    always #5 clk = ~clk;

    ysyx_22041207_axi_rd_slave dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_r_valid_i   (r_valid),
        .rx_r_ready_o   (r_ready),
        .rx_r_addr_i    (r_addr),
        .rx_r_size_i    (r_size),
        .rx_data_read_o (d_data),
        .rx_data_valid  (d_valid),
        .rx_data_ready  (d_ready),
        .rd_err         (rd_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte n of the result is byte (n+off) of the word when enabled and still inside the word.
    function automatic logic [63:0] model(input logic [63:0] w, input int off, input logic [7:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            if (s[n] && (n + off) < 8) r[8*n +: 8] = w[8*(n+off) +: 8];
        end
        return r;
    endfunction

    // Entered on a negedge with the responder idle; leaves after the data handshake.
    task automatic rd(input string tag, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] exp_d, input logic exp_e, output int lat);
        chk({tag, "/rdy"}, 64'(r_ready), 64'd1);
        r_valid = 1'b1;
        r_addr  = a;
        r_size  = s;
        @(negedge clk);
        r_valid = 1'b0;
        lat = 0;
        while (!d_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/vld"}, 64'(d_valid), 64'd1);
        chk({tag, "/data"}, d_data, exp_d);
        chk({tag, "/err"}, 64'(rd_err), 64'(exp_e));
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    task automatic chk_lat(input string tag, input int lat);
`ifdef RD_SLAVE_RAND_DELAY_EN
        chk({tag, "/lat"}, 64'(lat >= 2 && lat <= 9), 64'd1);
`else
        chk({tag, "/lat"}, 64'(lat), 64'd2);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 4; i++) dut.mem[i] = tb_mem[i];
        dut.mem[65535] = LAST_WORD;

        // reset release, then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t1/rdy", 64'(r_ready), 64'd1);
        chk("t1/vld", 64'(d_valid), 64'd0);
        chk("t1/data", d_data, 64'd0);
        chk("t1/err", 64'(rd_err), 64'd0);

        // single read, two-cycle latency, sticky hold
        r_valid = 1'b1; r_addr = 64'h8000_0004; r_size = SIZE_W;
        chk("t2/rdy_idle", 64'(r_ready), 64'd1);
        @(negedge clk);
        r_valid = 1'b0;
        chk("t2/rdy_wait", 64'(r_ready), 64'd0);
        chk("t2/vld_c0", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("t2/vld_c1", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("t2/vld_c2", 64'(d_valid), 64'd1);
        chk("t2/data", d_data, 64'h0000_0000_1122_3344);
        chk("t2/err", 64'(rd_err), 64'd0);
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("t2/rdy_after", 64'(r_ready), 64'd1);
        chk("t2/sticky_vld", 64'(d_valid), 64'd1);
        repeat (2) @(negedge clk);
        chk("t2/hold_vld", 64'(d_valid), 64'd1);
        chk("t2/hold_data", d_data, 64'h0000_0000_1122_3344);

        // back-to-back with ready held high; second address waits in RESP
        d_ready = 1'b1;
        r_valid = 1'b1; r_addr = 64'h8000_0000; r_size = SIZE_D;
        @(negedge clk);
        r_addr = 64'h8000_0008;
        chk("t3/rdy_wait", 64'(r_ready), 64'd0);
        chk("t3/vld_clr", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("t3/a_vld_c1", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("t3/a_vld", 64'(d_valid), 64'd1);
        chk("t3/a_data", d_data, tb_mem[0]);
        chk("t3/rdy_resp", 64'(r_ready), 64'd0);
        @(negedge clk);
        chk("t3/rdy_idle", 64'(r_ready), 64'd1);
        chk("t3/a_hold", d_data, tb_mem[0]);
        @(negedge clk);
        r_valid = 1'b0;
        chk("t3/b_accept", 64'(d_valid), 64'd0);
        chk("t3/b_rdy", 64'(r_ready), 64'd0);
        @(negedge clk);
        chk("t3/b_vld_c1", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("t3/b_vld", 64'(d_valid), 64'd1);
        chk("t3/b_data", d_data, tb_mem[1]);
        @(negedge clk);
        d_ready = 1'b0;
        chk("t3/b_done", 64'(r_ready), 64'd1);

        // range boundaries
        rd("t4_low", 64'h7FFF_FFF8, SIZE_D, 64'd0, 1'b1, lat);
        rd("t4_clr", 64'h8000_0003, 8'h07, 64'h0000_0000_0033_4455, 1'b0, lat);
        chk_lat("t4_clr", lat);
        rd("t4_last", 64'h8007_FFFF, SIZE_D, 64'h0000_0000_0000_0001, 1'b0, lat);
        rd("t4_end", 64'h8008_0000, SIZE_D, 64'd0, 1'b1, lat);

        // reset asserted while waiting
        r_valid = 1'b1; r_addr = 64'h8000_0010; r_size = SIZE_D;
        @(negedge clk);
        r_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5/rdy", 64'(r_ready), 64'd1);
        chk("t5/vld", 64'(d_valid), 64'd0);
        chk("t5/data", d_data, 64'd0);
        chk("t5/err", 64'(rd_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd("t5_after", 64'h8000_0010, SIZE_D, tb_mem[2], 1'b0, lat);
        chk_lat("t5_after", lat);

        // sweep of offsets/masks; latency fixed or within the random window
        for (int i = 0; i < 32; i++) begin
            int k;
            int off;
            k   = i % 4;
            off = (i * 3) % 8;
            rd($sformatf("t6_%0d", i), 64'h8000_0000 + 64'(8 * k + off), sz_tab[i % 8],
               model(tb_mem[k], off, sz_tab[i % 8]), 1'b0, lat);
            chk_lat($sformatf("t6_%0d", i), lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
